// File: rtl/dds_oscillator_if.sv
// Purpose : tone-control and DAC-sample bundle between a controller and dds_oscillator.
// Latency : none, this is wiring only.
// Backpressure : none. The sample side is a strobe-only stream, and the DAC must take every strobe.
//
// Signals (the names match the block's datasheet port names):
//   PHASE_INC  tuning word, added to the phase once per sample
//   WAVE_SEL   00 saw, 01 square, 10 triangle, 11 silence
//   GATE_IN    note on (1) / note off (0)
//   GAIN_IN    8-bit output gain, present only with DDS_OSC_GAIN_EN defined
//   DATA_OUT   12-bit offset-binary sample to the DAC
//   SAMPLE_STB one-cycle pulse when DATA_OUT takes a new value
//   BUSY       tone is running or ramping down
interface dds_oscillator_if #(
  parameter int PHASE_W = 24
);
  logic [PHASE_W-1:0] PHASE_INC;
  logic [1:0]         WAVE_SEL;
  logic               GATE_IN;
`ifdef DDS_OSC_GAIN_EN
  logic [7:0]         GAIN_IN;
`endif
  logic [11:0]        DATA_OUT;
  logic               SAMPLE_STB;
  logic               BUSY;

`ifdef DDS_OSC_GAIN_EN
  modport master (
    output PHASE_INC, WAVE_SEL, GATE_IN, GAIN_IN,
    input  DATA_OUT, SAMPLE_STB, BUSY
  );
  modport slave (
    input  PHASE_INC, WAVE_SEL, GATE_IN, GAIN_IN,
    output DATA_OUT, SAMPLE_STB, BUSY
  );
`else
  modport master (
    output PHASE_INC, WAVE_SEL, GATE_IN,
    input  DATA_OUT, SAMPLE_STB, BUSY
  );
  modport slave (
    input  PHASE_INC, WAVE_SEL, GATE_IN,
    output DATA_OUT, SAMPLE_STB, BUSY
  );
`endif
endinterface

// File: rtl/dds_oscillator.sv
// Purpose : DDS tone source. A phase accumulator steps once per sample tick, and a wave
//           shaper maps it to a 12-bit offset-binary sample for the SPI DAC. A gate-driven
//           FSM starts the tone and ramps the output back to midscale on release.
// Latency : a sample appears 1 cycle after its tick, or 2 cycles with DDS_OSC_GAIN_EN.
// Backpressure : none. SAMPLE_STB fires on every tick, including in IDLE, where the sample is 12'h800.
//
// Ports:
//   CLK_IN  system clock (single domain)
//   RST_IN  synchronous reset, active-high. It overrides everything, including a tone in progress.
//   bus     dds_oscillator_if.slave: PHASE_INC, WAVE_SEL, GATE_IN, [GAIN_IN] in;
//           DATA_OUT, SAMPLE_STB, BUSY out
// Option  : DDS_OSC_GAIN_EN adds GAIN_IN and a gain stage with one extra register.
//           The gain is 12'h800 + ((s - 2048) * GAIN_IN) >>> 8.
module dds_oscillator #(
  parameter int SAMPLE_DIV = 1134,
  parameter int PHASE_W    = 24,
  parameter int RAMP_STEP  = 16
) (
  input  logic            CLK_IN,
  input  logic            RST_IN,
  dds_oscillator_if.slave bus
);

  localparam int              CNT_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [11:0]     MID      = 12'h800;
  localparam logic [11:0]     STEP     = 12'(RAMP_STEP);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  state_e             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [11:0]        samp_q, samp_d;   // pre-gain sample; the release ramp works on this
  logic               stb_q, stb_d;
  logic               busy_q, busy_d;

  logic               tick;
  logic [11:0]        wave_now;
  logic [11:0]        wave_zero;
  logic [11:0]        ramp_v;

  // Maps the top 12 phase bits to the selected waveform.
  function automatic logic [11:0] wave_f(input logic [11:0] p, input logic [1:0] sel);
    logic [11:0] dbl;
    dbl = {p[10:0], 1'b0};
    case (sel)
      2'b00:   return p;
      2'b01:   return p[11] ? 12'hFFF : 12'h000;
      2'b10:   return p[11] ? ~dbl : dbl;
      default: return MID;
    endcase
  endfunction

  // Moves one step toward midscale. The step is clamped so it never overshoots 12'h800.
  function automatic logic [11:0] ramp_f(input logic [11:0] v);
    logic [12:0] up;
    logic [11:0] gap;
    up  = {1'b0, v} + {1'b0, STEP};
    gap = v - MID;
    if (v < MID) begin
      return (up >= {1'b0, MID}) ? MID : up[11:0];
    end else if (gap <= STEP) begin
      return MID;
    end else begin
      return v - STEP;
    end
  endfunction

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
    state_d   = state_q;
    phase_d   = phase_q;
    samp_d    = samp_q;
    stb_d     = tick;
    wave_now  = wave_f(phase_q[PHASE_W-1 -: 12], bus.WAVE_SEL);
    wave_zero = wave_f(12'h000, bus.WAVE_SEL);
    ramp_v    = ramp_f(samp_q);

    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.GATE_IN) begin
            state_d = ST_RUN;
            samp_d  = wave_zero;
            phase_d = bus.PHASE_INC;
          end else begin
            samp_d  = MID;
          end
        end
        ST_RUN: begin
          if (bus.GATE_IN) begin
            samp_d  = wave_now;
            phase_d = phase_q + bus.PHASE_INC;
          end else begin
            // The note-off tick already applies the first ramp step.
            // If that step lands on midscale, the FSM goes straight to IDLE.
            samp_d = ramp_v;
            if (ramp_v == MID) begin
              state_d = ST_IDLE;
              phase_d = '0;
            end else begin
              state_d = ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (bus.GATE_IN) begin
            state_d = ST_RUN;
            samp_d  = wave_zero;
            phase_d = bus.PHASE_INC;
          end else begin
            samp_d = ramp_v;
            if (ramp_v == MID) begin
              state_d = ST_IDLE;
              phase_d = '0;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          samp_d  = MID;
          phase_d = '0;
        end
      endcase
    end

    // BUSY follows the next state, so it changes on the same edge as the strobe.
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      phase_q <= '0;
      samp_q  <= MID;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      phase_q <= phase_d;
      samp_q  <= samp_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
    end
  end

`ifdef DDS_OSC_GAIN_EN
  // Gain stage. GAIN_IN is captured on the same tick as the sample. One register
  // after that, the scaled sample and its delayed strobe and BUSY appear together.
  logic [7:0]         gain_q, gain_d;
  logic [11:0]        out_q, out_d;
  logic               stb2_q, stb2_d;
  logic               busy2_q, busy2_d;
  logic signed [12:0] cen;
  logic signed [21:0] prod;

  always_comb begin
    gain_d  = tick ? bus.GAIN_IN : gain_q;
    cen     = $signed({1'b0, samp_q}) - 13'sd2048;
    prod    = 22'(cen) * $signed({14'd0, gain_q});
    // The true result lies inside 0..4095, so adding modulo 2^12 is exact.
    out_d   = 12'(prod >>> 8) + MID;
    stb2_d  = stb_q;
    busy2_d = busy_q;
  end

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      gain_q  <= '0;
      out_q   <= MID;
      stb2_q  <= 1'b0;
      busy2_q <= 1'b0;
    end else begin
      gain_q  <= gain_d;
      out_q   <= out_d;
      stb2_q  <= stb2_d;
      busy2_q <= busy2_d;
    end
  end

  assign bus.DATA_OUT   = out_q;
  assign bus.SAMPLE_STB = stb2_q;
  assign bus.BUSY       = busy2_q;
`else
  assign bus.DATA_OUT   = samp_q;
  assign bus.SAMPLE_STB = stb_q;
  assign bus.BUSY       = busy_q;
`endif

endmodule
